// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Registered-state sequencer for a multicycle MIPS datapath. Steps each
//   instruction through fetch, decode, execute, memory and writeback and
//   drives the shared ALU, memory port, IR, PC and register-file controls.
//   Supports R-type, addi, ori, lw, sw, beq and j. Handshakes with a
//   variable-latency memory, traps illegal opcodes and memory timeouts.
//
// Parameters
//   MEM_WAIT_MAX  max cycles in one memory state without ack before ERROR
//
// Ports
//   clk_i, rst_i (sync, active-low), start_i (run enable)
//   op_i          opcode from IR, stable from DECODE until the next FETCH
//   mem_ack_i     memory completion, looked at only in memory states
//   pc_write_o, pc_write_cond_o, pc_source_o     PC update controls
//   i_or_d_o, mem_read_o, mem_write_o, ir_write_o memory/IR controls
//   mem_to_reg_o, reg_dst_o, reg_write_o         register-file controls
//   alu_src_a_o, alu_src_b_o, alu_op_o, zext_o    ALU controls
//   instr_done_o  pulse on the final state of each instruction
//   illegal_o, timeout_o  sticky error flags; state_o  debug state code
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter int unsigned MEM_WAIT_MAX = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [5:0] op_i,
    input  logic       mem_ack_i,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic [1:0] pc_source_o,
    output logic       i_or_d_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       mem_to_reg_o,
    output logic       reg_dst_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic       zext_o,
    output logic       instr_done_o,
    output logic       illegal_o,
    output logic       timeout_o,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_EXEC   = 4'd7,
        ST_RWB    = 4'd8,
        ST_BRANCH = 4'd9,
        ST_JUMP   = 4'd10,
        ST_IEXEC  = 4'd11,
        ST_IWB    = 4'd12,
        ST_ERROR  = 4'd13
    } state_t;

    localparam int unsigned    CW        = (MEM_WAIT_MAX > 2) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT_MAX - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          illegal_q, illegal_d;
    logic          timeout_q, timeout_d;
    // lw/sw is remembered at DECODE so MEMADR does not have to re-examine
    // the load/store opcodes.
    logic          is_load_q, is_load_d;
    logic          in_mem;
    logic          end_instr;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            is_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            is_load_q <= is_load_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        illegal_d       = illegal_q;
        timeout_d       = timeout_q;
        is_load_d       = is_load_q;
        in_mem          = 1'b0;
        end_instr       = 1'b0;
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        pc_source_o     = 2'b00;
        i_or_d_o        = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        ir_write_o      = 1'b0;
        mem_to_reg_o    = 1'b0;
        reg_dst_o       = 1'b0;
        reg_write_o     = 1'b0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = 2'b00;
        alu_op_o        = 2'b00;
        zext_o          = 1'b0;
        instr_done_o    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                in_mem      = 1'b1;
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'b01;
                // IR and PC+4 are captured on the same cycle the memory
                // delivers the instruction word.
                ir_write_o  = mem_ack_i;
                pc_write_o  = mem_ack_i;
                if (mem_ack_i) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                alu_src_b_o = 2'b11;
                case (op_i)
                    6'h00: state_d = ST_EXEC;
                    6'h23: begin state_d = ST_MEMADR; is_load_d = 1'b1; end
                    6'h2B: begin state_d = ST_MEMADR; is_load_d = 1'b0; end
                    6'h04: state_d = ST_BRANCH;
                    6'h02: state_d = ST_JUMP;
                    6'h08,
                    6'h0D: state_d = ST_IEXEC;
                    default: begin
                        state_d   = ST_ERROR;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            ST_MEMADR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                state_d     = is_load_q ? ST_MEMRD : ST_MEMWR;
            end
            ST_MEMRD: begin
                in_mem     = 1'b1;
                mem_read_o = 1'b1;
                i_or_d_o   = 1'b1;
                if (mem_ack_i) state_d = ST_MEMWB;
            end
            ST_MEMWB: begin
                mem_to_reg_o = 1'b1;
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
                end_instr    = 1'b1;
            end
            ST_MEMWR: begin
                in_mem       = 1'b1;
                mem_write_o  = 1'b1;
                i_or_d_o     = 1'b1;
                instr_done_o = mem_ack_i;
                end_instr    = mem_ack_i;
            end
            ST_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 2'b11;
                state_d     = ST_RWB;
            end
            ST_RWB: begin
                reg_dst_o    = 1'b1;
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
                end_instr    = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a_o     = 1'b1;
                alu_op_o        = 2'b01;
                pc_write_cond_o = 1'b1;
                pc_source_o     = 2'b01;
                instr_done_o    = 1'b1;
                end_instr       = 1'b1;
            end
            ST_JUMP: begin
                pc_write_o   = 1'b1;
                pc_source_o  = 2'b10;
                instr_done_o = 1'b1;
                end_instr    = 1'b1;
            end
            ST_IEXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                if (op_i == 6'h0D) begin
                    alu_op_o = 2'b10;
                    zext_o   = 1'b1;
                end
                state_d = ST_IWB;
            end
            ST_IWB: begin
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
                end_instr    = 1'b1;
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: state_d = ST_IDLE;
        endcase

        // Back-to-back instructions: final state goes straight to FETCH.
        if (end_instr) state_d = start_i ? ST_FETCH : ST_IDLE;

        // Ack wins over timeout, so only the no-ack case can expire.
        if (in_mem && !mem_ack_i && (wait_q == WAIT_LAST)) begin
            state_d   = ST_ERROR;
            timeout_d = 1'b1;
        end

        // Every memory state is left on ack or timeout, so clearing whenever
        // we are not still waiting also clears the counter on entry.
        if (in_mem && !mem_ack_i && (wait_q != WAIT_LAST)) wait_d = wait_q + 1'b1;
        else                                                wait_d = '0;
    end

    assign illegal_o = illegal_q;
    assign timeout_o = timeout_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic       clk_i = 1'b0;
    logic       rst_i, start_i, mem_ack_i;
    logic [5:0] op_i;
    logic       pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o;
    logic       ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o;
    logic       zext_o, instr_done_o, illegal_o, timeout_o;
    logic [1:0] pc_source_o, alu_src_b_o, alu_op_o;
    logic [3:0] state_o;

    always #5 clk_i = ~clk_i;

    multicycle_control #(.MEM_WAIT_MAX(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
        .mem_ack_i(mem_ack_i),
        .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o),
        .pc_source_o(pc_source_o), .i_or_d_o(i_or_d_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .ir_write_o(ir_write_o), .mem_to_reg_o(mem_to_reg_o),
        .reg_dst_o(reg_dst_o), .reg_write_o(reg_write_o),
        .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
        .alu_op_o(alu_op_o), .zext_o(zext_o), .instr_done_o(instr_done_o),
        .illegal_o(illegal_o), .timeout_o(timeout_o), .state_o(state_o)
    );

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       zext;
        logic       instr_done;
        logic       illegal;
        logic       timeout;
        logic [3:0] state;
    } outs_t;

    typedef struct {
        logic       rst;
        logic       start;
        logic [5:0] op;
        logic       ack;
        outs_t      exp;
        string      nm;
    } vec_t;

    // Expected output sets per state, written from the control table.
    localparam outs_t E_IDLE      = '0;
    localparam outs_t E_FETCH     = '{mem_read:1'b1, alu_src_b:2'b01, state:4'd1, default:'0};
    localparam outs_t E_FETCH_ACK = '{mem_read:1'b1, alu_src_b:2'b01, ir_write:1'b1,
                                      pc_write:1'b1, state:4'd1, default:'0};
    localparam outs_t E_DECODE    = '{alu_src_b:2'b11, state:4'd2, default:'0};
    localparam outs_t E_MEMADR    = '{alu_src_a:1'b1, alu_src_b:2'b10, state:4'd3, default:'0};
    localparam outs_t E_MEMRD     = '{mem_read:1'b1, i_or_d:1'b1, state:4'd4, default:'0};
    localparam outs_t E_MEMWB     = '{mem_to_reg:1'b1, reg_write:1'b1, instr_done:1'b1,
                                      state:4'd5, default:'0};
    localparam outs_t E_MEMWR     = '{mem_write:1'b1, i_or_d:1'b1, state:4'd6, default:'0};
    localparam outs_t E_MEMWR_ACK = '{mem_write:1'b1, i_or_d:1'b1, instr_done:1'b1,
                                      state:4'd6, default:'0};
    localparam outs_t E_EXEC      = '{alu_src_a:1'b1, alu_op:2'b11, state:4'd7, default:'0};
    localparam outs_t E_RWB       = '{reg_dst:1'b1, reg_write:1'b1, instr_done:1'b1,
                                      state:4'd8, default:'0};
    localparam outs_t E_BRANCH    = '{alu_src_a:1'b1, alu_op:2'b01, pc_write_cond:1'b1,
                                      pc_source:2'b01, instr_done:1'b1, state:4'd9, default:'0};
    localparam outs_t E_JUMP      = '{pc_write:1'b1, pc_source:2'b10, instr_done:1'b1,
                                      state:4'd10, default:'0};
    localparam outs_t E_ORI       = '{alu_src_a:1'b1, alu_src_b:2'b10, alu_op:2'b10,
                                      zext:1'b1, state:4'd11, default:'0};
    localparam outs_t E_ADDI      = '{alu_src_a:1'b1, alu_src_b:2'b10, state:4'd11, default:'0};
    localparam outs_t E_IWB       = '{reg_write:1'b1, instr_done:1'b1, state:4'd12, default:'0};
    localparam outs_t E_ERR_TO    = '{timeout:1'b1, state:4'd13, default:'0};
    localparam outs_t E_ERR_IL    = '{illegal:1'b1, state:4'd13, default:'0};

    vec_t  tbl[$];
    outs_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    function automatic void add(input logic rst, input logic st, input logic [5:0] op,
                                input logic ack, input outs_t exp, input string nm);
        vec_t v;
        v.rst = rst; v.start = st; v.op = op; v.ack = ack; v.exp = exp; v.nm = nm;
        tbl.push_back(v);
    endfunction

    // Drive one cycle of inputs on the falling edge, queue the expectation,
    // then compare the DUT outputs before the next rising edge.
    task automatic apply(input logic rst, input logic st, input logic [5:0] op,
                         input logic ack, input outs_t exp, input string nm);
        outs_t got, want;
        @(negedge clk_i);
        rst_i = rst; start_i = st; op_i = op; mem_ack_i = ack;
        exp_q.push_back(exp);
        #1;
        got = '{pc_write:pc_write_o, pc_write_cond:pc_write_cond_o, pc_source:pc_source_o,
                i_or_d:i_or_d_o, mem_read:mem_read_o, mem_write:mem_write_o,
                ir_write:ir_write_o, mem_to_reg:mem_to_reg_o, reg_dst:reg_dst_o,
                reg_write:reg_write_o, alu_src_a:alu_src_a_o, alu_src_b:alu_src_b_o,
                alu_op:alu_op_o, zext:zext_o, instr_done:instr_done_o,
                illegal:illegal_o, timeout:timeout_o, state:state_o};
        want = exp_q.pop_front();
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h (state %0d) expected %h (state %0d)",
                     nm, got, got.state, want, want.state);
        end else begin
            $display("ok   %s: outputs %h state %0d", nm, got, got.state);
        end
    endtask

    initial begin
        rst_i = 1'b0; start_i = 1'b0; op_i = 6'h00; mem_ack_i = 1'b0;
        repeat (2) @(posedge clk_i);

        // Reset, then R-type with ack every cycle: 1,2,7,8
        add(1, 0, 6'h00, 0, E_IDLE,      "rst_idle");
        add(1, 1, 6'h00, 0, E_IDLE,      "idle_start");
        add(1, 1, 6'h00, 1, E_FETCH_ACK, "r_fetch");
        add(1, 1, 6'h00, 0, E_DECODE,    "r_decode");
        add(1, 1, 6'h00, 0, E_EXEC,      "r_exec");
        add(1, 1, 6'h00, 0, E_RWB,       "r_rwb");
        // lw with three MEMRD cycles: 7 cycles total
        add(1, 1, 6'h23, 1, E_FETCH_ACK, "lw_fetch");
        add(1, 1, 6'h23, 0, E_DECODE,    "lw_decode");
        add(1, 1, 6'h23, 0, E_MEMADR,    "lw_memadr");
        add(1, 1, 6'h23, 0, E_MEMRD,     "lw_rd_w0");
        add(1, 1, 6'h23, 0, E_MEMRD,     "lw_rd_w1");
        add(1, 1, 6'h23, 1, E_MEMRD,     "lw_rd_ack");
        add(1, 1, 6'h23, 0, E_MEMWB,     "lw_memwb");
        // beq and j: 3 cycles each
        add(1, 1, 6'h04, 1, E_FETCH_ACK, "beq_fetch");
        add(1, 1, 6'h04, 0, E_DECODE,    "beq_decode");
        add(1, 1, 6'h04, 0, E_BRANCH,    "beq_branch");
        add(1, 1, 6'h02, 1, E_FETCH_ACK, "j_fetch");
        add(1, 1, 6'h02, 0, E_DECODE,    "j_decode");
        add(1, 1, 6'h02, 0, E_JUMP,      "j_jump");
        // ori vs addi
        add(1, 1, 6'h0D, 1, E_FETCH_ACK, "ori_fetch");
        add(1, 1, 6'h0D, 0, E_DECODE,    "ori_decode");
        add(1, 1, 6'h0D, 0, E_ORI,       "ori_iexec");
        add(1, 1, 6'h0D, 0, E_IWB,       "ori_iwb");
        add(1, 1, 6'h08, 1, E_FETCH_ACK, "addi_fetch");
        add(1, 1, 6'h08, 0, E_DECODE,    "addi_decode");
        add(1, 1, 6'h08, 0, E_ADDI,      "addi_iexec");
        add(1, 1, 6'h08, 0, E_IWB,       "addi_iwb");
        // sw with one wait, then start low ends in IDLE
        add(1, 1, 6'h2B, 1, E_FETCH_ACK, "sw_fetch");
        add(1, 1, 6'h2B, 0, E_DECODE,    "sw_decode");
        add(1, 1, 6'h2B, 0, E_MEMADR,    "sw_memadr");
        add(1, 1, 6'h2B, 0, E_MEMWR,     "sw_wr_w0");
        add(1, 0, 6'h2B, 1, E_MEMWR_ACK, "sw_wr_ack");
        add(1, 0, 6'h00, 0, E_IDLE,      "sw_to_idle");
        // FETCH ack on the last allowed cycle completes normally
        add(1, 1, 6'h02, 0, E_IDLE,      "lim_start");
        add(1, 1, 6'h02, 0, E_FETCH,     "lim_w0");
        add(1, 1, 6'h02, 0, E_FETCH,     "lim_w1");
        add(1, 1, 6'h02, 0, E_FETCH,     "lim_w2");
        add(1, 1, 6'h02, 1, E_FETCH_ACK, "lim_ack_last");
        add(1, 1, 6'h02, 0, E_DECODE,    "lim_decode");
        add(1, 1, 6'h02, 0, E_JUMP,      "lim_jump");
        // FETCH with no ack for 4 cycles -> ERROR with timeout
        add(1, 1, 6'h00, 0, E_FETCH,     "to_w0");
        add(1, 1, 6'h00, 0, E_FETCH,     "to_w1");
        add(1, 1, 6'h00, 0, E_FETCH,     "to_w2");
        add(1, 1, 6'h00, 0, E_FETCH,     "to_w3");
        add(1, 1, 6'h00, 0, E_ERR_TO,    "to_error");
        add(1, 0, 6'h00, 0, E_ERR_TO,    "to_hold_s0");
        add(1, 1, 6'h00, 1, E_ERR_TO,    "to_hold_s1");
        add(0, 1, 6'h00, 0, E_ERR_TO,    "to_rst_edge");
        add(1, 0, 6'h00, 0, E_IDLE,      "to_cleared");
        // Illegal opcode
        add(1, 1, 6'h3F, 0, E_IDLE,      "il_start");
        add(1, 1, 6'h3F, 1, E_FETCH_ACK, "il_fetch");
        add(1, 1, 6'h3F, 0, E_DECODE,    "il_decode");
        add(1, 0, 6'h3F, 0, E_ERR_IL,    "il_error");
        add(1, 1, 6'h3F, 0, E_ERR_IL,    "il_hold");
        add(0, 1, 6'h3F, 0, E_ERR_IL,    "il_rst_edge");
        add(1, 0, 6'h00, 0, E_IDLE,      "il_cleared");
        // Reset in the middle of a memory wait
        add(1, 1, 6'h00, 0, E_IDLE,      "mr_start");
        add(0, 1, 6'h00, 0, E_FETCH,     "mr_rst_fetch");
        add(1, 0, 6'h00, 0, E_IDLE,      "mr_idle");

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i].rst, tbl[i].start, tbl[i].op, tbl[i].ack, tbl[i].exp, tbl[i].nm);

        // Hand-written: lw that never gets its data ack times out in MEMRD.
        apply(1, 1, 6'h23, 0, E_IDLE,      "h_start");
        apply(1, 1, 6'h23, 1, E_FETCH_ACK, "h_fetch");
        apply(1, 1, 6'h23, 0, E_DECODE,    "h_decode");
        apply(1, 1, 6'h23, 0, E_MEMADR,    "h_memadr");
        for (int w = 0; w < 4; w++)
            apply(1, 1, 6'h23, 0, E_MEMRD, "h_rd_wait");
        apply(1, 1, 6'h23, 0, E_ERR_TO,    "h_rd_timeout");
        apply(0, 0, 6'h00, 0, E_ERR_TO,    "h_rst_edge");
        apply(1, 0, 6'h00, 0, E_IDLE,      "h_cleared");

        // Hand-written: sw acked on the last allowed MEMWR cycle finishes.
        apply(1, 1, 6'h2B, 0, E_IDLE,      "h2_start");
        apply(1, 1, 6'h2B, 1, E_FETCH_ACK, "h2_fetch");
        apply(1, 1, 6'h2B, 0, E_DECODE,    "h2_decode");
        apply(1, 1, 6'h2B, 0, E_MEMADR,    "h2_memadr");
        for (int w = 0; w < 3; w++)
            apply(1, 1, 6'h2B, 0, E_MEMWR, "h2_wr_wait");
        apply(1, 0, 6'h2B, 1, E_MEMWR_ACK, "h2_wr_ack_last");
        apply(1, 0, 6'h00, 0, E_IDLE,      "h2_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle sequencer for the MIPS datapath: a registered-state FSM that steps each instruction through fetch, decode, execute, memory and writeback.
- Drives the shared ALU, memory port, IR, PC and register-file enables, replacing the single-cycle opcode decoder when the datapath is built multicycle.
- Supports R-type, addi, ori, lw, sw, beq and j.
- Handshakes with a variable-latency memory and traps illegal opcodes and memory timeouts.

Parameters:
- MEM_WAIT_MAX, 16: maximum cycles spent in one memory state without mem_ack_i before the FSM enters ERROR (range 2..256).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-low
- start_i  in  1  run enable, level-sensitive
- op_i  in  6  opcode from the IR register; stable from DECODE until the next FETCH
- mem_ack_i  in  1  memory completion; valid only while mem_read_o or mem_write_o is high
- pc_write_o  out  1  unconditional PC load
- pc_write_cond_o  out  1  PC load if ALU zero
- pc_source_o  out  2  PC mux select: 00 ALU result, 01 ALUOut, 10 jump target
- i_or_d_o  out  1  memory address select: 0 PC, 1 ALUOut
- mem_read_o  out  1  memory read request
- mem_write_o  out  1  memory write request
- ir_write_o  out  1  IR load
- mem_to_reg_o  out  1  writeback source: 1 MDR, 0 ALUOut
- reg_dst_o  out  1  destination register: 1 rd, 0 rt
- reg_write_o  out  1  register-file write
- alu_src_a_o  out  1  ALU A select: 0 PC, 1 rs
- alu_src_b_o  out  2  ALU B select: 00 rt, 01 const 4, 10 immediate, 11 immediate<<2
- alu_op_o  out  2  ALU operation: 00 add, 01 sub, 10 or, 11 R-type (funct)
- zext_o  out  1  zero-extend immediate (ori)
- instr_done_o  out  1  one-cycle pulse on the final state of each instruction
- illegal_o  out  1  sticky: illegal opcode
- timeout_o  out  1  sticky: memory timeout
- state_o  out  4  current state code, for debug

Behaviour:
- State encoding: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, RWB 8, BRANCH 9, JUMP 10, IEXEC 11, IWB 12, ERROR 13.
- Reset (rst_i=0 at a clock edge): state goes to IDLE, wait counter and sticky flags clear. All outputs are 0 while in IDLE.
- Reset takes priority over every transition, including mid-instruction or mid-memory-wait.
- Outputs are Moore decodes of state, except ir_write_o and pc_write_o in FETCH, which equal mem_ack_i. Signals not listed below for a state are 0.
- IDLE: start_i=1 -> FETCH.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - Stay until ack; on ack -> DECODE.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00.
  - op 00 -> EXEC; 23 or 2B -> MEMADR; 04 -> BRANCH; 02 -> JUMP; 08 or 0D -> IEXEC; any other opcode -> ERROR with illegal_o set.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_read=1, i_or_d=1. On ack -> MEMWB.
- MEMWB: mem_to_reg=1, reg_dst=0, reg_write=1, instr_done=1.
- MEMWR: mem_write=1, i_or_d=1. On ack: instr_done=1 and instruction ends.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=11. -> RWB.
- RWB: reg_dst=1, reg_write=1, instr_done=1.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1.
- JUMP: pc_write=1, pc_source=10, instr_done=1.
- IEXEC: alu_src_a=1, alu_src_b=10. addi: alu_op=00, zext=0. ori: alu_op=10, zext=1. -> IWB.
- IWB: reg_dst=0, reg_write=1, instr_done=1.
- Instruction end (all final states): go to FETCH if start_i=1, else IDLE. No bubble cycle between instructions.
- Cycle counts with zero-wait memory: beq and j 3; R-type, addi, ori and sw 4; lw 5. Each memory wait cycle adds 1.
- Wait counter:
  - Clears on entry to FETCH, MEMRD or MEMWR; increments each cycle spent in one of those states without ack.
  - No ack when the counter reaches MEM_WAIT_MAX-1 -> ERROR with timeout_o set.
  - Ack on that same last cycle completes normally; ack takes priority over timeout.
- ERROR: all datapath controls are 0. Held until reset; start_i is ignored.
- Opcode values other than 04, 02, 08 and 0D are never sampled outside DECODE.

Test Plan:
- Reset and start: reset, start_i=1, ack every cycle, op=00 -> states 1,2,7,8,1. instr_done_o high in RWB only. RWB shows reg_dst=1, reg_write=1.
- lw with 3-cycle ack delay in MEMRD: op=23 -> MEMRD held 3 cycles with mem_read=1, i_or_d=1, then MEMWB with mem_to_reg=1. Total 7 cycles.
- Branch and jump: op=04 -> BRANCH shows pc_write_cond=1, alu_op=01, pc_source=01. op=02 -> JUMP shows pc_write=1, pc_source=10. Each instruction takes 3 cycles.
- ori vs addi: IEXEC shows alu_op=10, zext=1 for op=0D, and alu_op=00, zext=0 for op=08.
- Illegal opcode: op=3F in DECODE -> ERROR, illegal_o=1; start_i toggling has no effect; rst_i=0 -> IDLE with flags 0.
- Timeout with MEM_WAIT_MAX=4: no ack in FETCH -> ERROR after 4 cycles, timeout_o=1. Ack on the 4th cycle instead -> DECODE.
